quo_bcd_conv: RTL and testbench



---
 rtl/quo_bcd_conv.sv | 132 +++++++++++++
 tb/tb_quo_bcd_conv.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quo_bcd_conv.sv
// -----------------------------------------------------------------------------
// quo_bcd_conv
//
// Converts the divider's unsigned quotient to packed BCD using an iterative
// shift-add-3 (double-dabble) loop, one quotient bit per clock.
// A divide-by-zero input bypasses conversion and returns an error result.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds its data stable from raising valid until that edge.
//   in_ready depends only on internal state and rst, never on in_valid.
//   out_valid, bcd and err are registered. Once out_valid is raised, bcd and
//   err stay stable until the transfer edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   quotient/dbz pair is valid
//   in_ready   block can accept a new pair (IDLE and not in reset)
//   quo        quotient from the divider, WIDTH bits
//   dbz        divide-by-zero flag from the divider
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   bcd        packed BCD result: [3:0] ones, [7:4] tens, [11:8] hundreds, ...
//   err        result corresponds to a divide-by-zero input
//
// Parameters:
//   WIDTH   quotient width in bits
//   DIGITS  number of BCD digits; 10**DIGITS must exceed 2**WIDTH-1
//
// The FSM state register is named 'state' so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module quo_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quo,
    input  logic                  dbz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  err
);

    localparam int BW = 4 * DIGITS;   // BCD field width
    localparam int SW = BW + WIDTH;   // full shift register width
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] sreg;      // {bcd digits, remaining quotient bits}
    logic [CW-1:0] cnt;       // number of shifts already performed
    logic [SW-1:0] sreg_adj;  // after the +3 correction
    logic [SW-1:0] sreg_next; // after the correction and the shift
    logic          last_shift;

    // All nibbles are corrected from the pre-shift value, then the whole
    // register shifts left once. A nibble >= 5 becomes at most 12, so the
    // correction never carries into the next digit.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg[WIDTH + 4*i +: 4] >= 4'd5) begin
                sreg_adj[WIDTH + 4*i +: 4] = sreg[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        sreg_next = sreg_adj << 1;
    end

    // The shift at count WIDTH-1 is the WIDTH-th and final one.
    assign last_shift = (cnt == CW'(WIDTH - 1));

    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            bcd       <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (dbz) begin
                            // Error results skip conversion. The quotient is ignored.
                            bcd       <= '0;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            sreg  <= {{BW{1'b0}}, quo};
                            cnt   <= '0;
                            err   <= 1'b0;
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    sreg <= sreg_next;
                    cnt  <= cnt + 1'b1;
                    if (last_shift) begin
                        bcd       <= sreg_next[SW-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // bcd and err keep their last values after the transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quo_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_quo_bcd_conv
//
// Directed bench for quo_bcd_conv.
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge.
//
// A cycle-level model checks in_ready, out_valid, bcd and err on every cycle.
// The model builds each expected value from decimal arithmetic. A queue
// scoreboard checks the order of results at each output transfer.
// -----------------------------------------------------------------------------
module tb_quo_bcd_conv;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WIDTH-1:0] quo;
    logic          dbz;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] bcd;
    logic          err;

    always #5 clk = ~clk;

    int cyc = 0;               // count of rising edges
    always @(posedge clk) cyc++;

    quo_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quo       (quo),
        .dbz       (dbz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .err       (err)
    );

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: peel off decimal digits with plain division.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // ---------------- model + scoreboard ----------------
    bit            m_idle  = 1'b1;
    int            m_cnt   = 0;     // cycles left until a conversion finishes
    bit            m_valid = 1'b0;
    logic [BW-1:0] m_bcd   = '0;
    logic [BW-1:0] m_pend  = '0;
    bit            m_err   = 1'b0;
    logic [BW:0]   exp_q[$];        // {err, bcd} in issue order

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_idle && !rst));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("bcd_while_valid", 32'(bcd), 32'(m_bcd));
                chk("err_while_valid", 32'(err), 32'(m_err));
            end
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected actual=%0h expected=none", {err, bcd});
                end else begin
                    logic [BW:0] e;
                    e = exp_q.pop_front();
                    chk("sb_result", 32'({err, bcd}), 32'(e));
                end
                n_out++;
            end
        end
        // Predict the state after the next rising edge.
        if (rst) begin
            m_idle  = 1'b1;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_bcd   = '0;
            m_err   = 1'b0;
            exp_q.delete();
        end else if (m_idle && in_valid) begin
            m_idle = 1'b0;
            if (dbz) begin
                m_valid = 1'b1;
                m_bcd   = '0;
                m_err   = 1'b1;
                exp_q.push_back({1'b1, {BW{1'b0}}});
            end else begin
                m_cnt  = WIDTH;
                m_pend = to_bcd(int'(quo));
                m_err  = 1'b0;
                exp_q.push_back({1'b0, to_bcd(int'(quo))});
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1'b1;
                m_bcd   = m_pend;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    // Offers one pair and returns the edge count of the accepting edge.
    task automatic send(input logic [WIDTH-1:0] q, input logic d, output int acc);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        quo      = q;
        dbz      = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        dbz      = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // lat = number of the rising edge, counted from the accept edge, at which
    // downstream first sees out_valid high.
    task automatic wait_valid(input int acc, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                lat = cyc - acc + 1;
            end
        end
        if (!got) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    int            acc, lat, n0, prev, idx;
    bit            hs;
    int            sw_q[6]            = '{0, 9, 10, 99, 100, 128};
    logic [BW-1:0] sw_e[6]            = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    int            st_q[5]            = '{3, 250, 17, 64, 111};

    initial begin
        rst = 1'b1; in_valid = 1'b0; quo = '0; dbz = 1'b0; out_ready = 1'b1;
        chk_en = 1'b1;

        // Pin the reference model to hand-computed values.
        chk("model_255", 32'(to_bcd(255)), 32'h255);
        chk("model_128", 32'(to_bcd(128)), 32'h128);
        chk("model_0",   32'(to_bcd(0)),   32'h000);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd",       32'(bcd),       32'h000);
        chk("rst_err",       32'(err),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 1: full-scale conversion, latency and return to ready.
        send(8'd255, 1'b0, acc);
        wait_valid(acc, lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_bcd", 32'(bcd), 32'h255);
        chk("t1_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("t1_ready_again", 32'(in_ready), 32'd1);

        // 2: sweep with literal expectations, then exhaustive.
        for (int i = 0; i < 6; i++) begin
            send(WIDTH'(sw_q[i]), 1'b0, acc);
            wait_valid(acc, lat);
            chk("t2_sweep_bcd", 32'(bcd), 32'(sw_e[i]));
            chk("t2_sweep_err", 32'(err), 32'd0);
        end
        for (int v = 0; v < 256; v++) begin
            send(WIDTH'(v), 1'b0, acc);
            wait_valid(acc, lat);
            chk("t2_exh_latency", 32'(lat), 32'd9);
        end

        // 3: divide-by-zero path, then a normal conversion.
        send(8'hA5, 1'b1, acc);
        wait_valid(acc, lat);
        chk("t3_dbz_latency", 32'(lat), 32'd1);
        chk("t3_dbz_bcd", 32'(bcd), 32'h000);
        chk("t3_dbz_err", 32'(err), 32'd1);
        send(8'd42, 1'b0, acc);
        wait_valid(acc, lat);
        chk("t3_after_bcd", 32'(bcd), 32'h042);
        chk("t3_after_err", 32'(err), 32'd0);

        // 4: backpressure with a request offered during the stall.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'd200, 1'b0, acc);
        wait_valid(acc, lat);
        n0 = n_out;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = (k == 2);
            quo      = 8'd5;
            @(negedge clk);
            chk("t4_hold_bcd", 32'(bcd), 32'h200);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_one_consumed", 32'(n_out), 32'(n0 + 1));
        chk("t4_valid_low", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_extra", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // 5: reset during conversion, on the 4th conversion cycle.
        send(8'd77, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_bcd", 32'(bcd), 32'h000);
        chk("t5_err", 32'(err), 32'd0);
        n0 = n_out;
        repeat (15) @(negedge clk);
        chk("t5_no_output", 32'(n_out), 32'(n0));
        send(8'd77, 1'b0, acc);
        wait_valid(acc, lat);
        chk("t5_bcd_77", 32'(bcd), 32'h077);
        chk("t5_latency", 32'(lat), 32'd9);

        // 6: back-to-back stream with in_valid held high.
        @(posedge clk); #1;
        n0 = n_out; prev = -1; idx = 0;
        in_valid = 1'b1;
        quo = WIDTH'(st_q[0]);
        for (int c = 0; c < 200 && idx < 5; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                if (prev >= 0) chk("t6_interval", 32'(cyc - prev), 32'd10);
                prev = cyc;
                idx++;
                if (idx < 5) quo = WIDTH'(st_q[idx]);
                else         in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("t6_all_accepted", 32'(idx), 32'd5);
        repeat (15) @(negedge clk);
        chk("t6_all_out", 32'(n_out - n0), 32'd5);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
